load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_pkg.sv | 45 ++++
 rtl/load_extract.sv | 40 ++++
 rtl/load_unit.sv | 157 +++++++++++++++
 tb/tb_load_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// -----------------------------------------------------------------------------
// load_pkg
// Shared definitions for the load unit: load-type encodings, the FSM state
// type and small decode helpers used by load_unit and load_extract.
// Optional feature macro consumed by users of this package: LOAD_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package load_pkg;

    // Load-type encodings presented on the op port
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    // Load FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

    // True for the five defined load types
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True when the byte offset is not naturally aligned for the access size
    function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] offset);
        logic mis;
        case (op)
            OP_LH, OP_LHU: mis = offset[0];
            OP_LW:         mis = (offset != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational byte/half/word selection from a 32-bit memory word plus sign or
// zero extension according to the load type.
// Ports:
//   i_op     [2:0]  load type (load_pkg OP_* encodings)
//   i_offset [1:0]  byte offset of the load within the word
//   i_rdata  [31:0] memory read word
//   o_data   [31:0] extended load result (0 for an undefined op)
// -----------------------------------------------------------------------------
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Misaligned halves are truncated to the half selected by offset[1]
    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    // Extension per load type
    always_comb begin
        o_data = 32'd0;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LW:   o_data = i_rdata;
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LHU:  o_data = {16'd0, w_half};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
// Executes one CPU load at a time: issues a single word-aligned memory read,
// waits for read data (bounded by TIMEOUT_CYC cycles), extracts and extends
// the addressed byte/half/word and returns a one-cycle response.
// Parameters:
//   TIMEOUT_CYC  maximum WAIT cycles before the load reports a bus error
// Optional feature macro:
//   LOAD_MISALIGN_TRAP_EN  when defined, misaligned lh/lhu/lw fault without a
//                          memory access; when undefined they are truncated.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        load request handshake (ready only in IDLE)
//   op[2:0], addr[31:0]        load type and byte address
//   mem_rd_en, mem_addr[31:0]  one-cycle read strobe and aligned address
//   mem_rvalid, mem_rdata      memory read data return
//   rsp_valid, rsp_data, rsp_err  one-cycle response; data/err held afterwards
// -----------------------------------------------------------------------------
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    // Only the byte offset is needed after issue; mem_addr is built at accept
    logic [1:0]         r_offset;
    logic               r_req_ready;
    logic               r_mem_rd_en;
    logic [31:0]        r_mem_addr;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;

    logic               w_trap;
    logic               w_fault;
    logic               w_timeout;
    logic [31:0]        w_ext_data;

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_trap = op_is_misaligned(op, addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    assign w_fault   = !op_is_legal(op) || w_trap;
    assign w_timeout = (r_cnt == CNT_LAST);

    load_extract u_extract (
        .i_op     (r_op),
        .i_offset (r_offset),
        .i_rdata  (mem_rdata),
        .o_data   (w_ext_data)
    );

    // Load FSM with wait counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= 3'b000;
            r_offset    <= 2'b00;
            r_req_ready <= 1'b1;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_op        <= op;
                        r_offset    <= addr[1:0];
                        r_req_ready <= 1'b0;
                        r_cnt       <= '0;
                        if (w_fault) begin
                            // Faulting loads skip the memory entirely
                            r_state     <= ST_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'd0;
                        end else begin
                            r_state     <= ST_REQ;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_state     <= ST_WAIT;
                    r_mem_rd_en <= 1'b0;
                    r_mem_addr  <= 32'd0;
                    r_cnt       <= '0;
                end
                ST_WAIT: begin
                    // Data wins over a timeout in the same cycle
                    if (mem_rvalid) begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_ext_data;
                    end else if (w_timeout) begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RSP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_req_ready <= 1'b1;
                    r_mem_rd_en <= 1'b0;
                    r_mem_addr  <= 32'd0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_unit.sv
// -----------------------------------------------------------------------------
// tb_load_unit
// Self-checking bench for load_unit: directed loads from the requirements plus
// randomized loads compared against an arithmetic reference model.
// Honors LOAD_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_load_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (o == 3'b010) || (o == 3'b100) || (o == 3'b101);
    endfunction

    function automatic bit is_trap(input logic [2:0] o, input logic [31:0] a);
`ifdef LOAD_MISALIGN_TRAP_EN
        if ((o == 3'b001 || o == 3'b101) && (a % 32'd2) != 32'd0) return 1'b1;
        if (o == 3'b010 && (a % 32'd4) != 32'd0) return 1'b1;
        return 1'b0;
`else
        return (o == 3'b111) && (a == 32'd1) && 1'b0;
`endif
    endfunction

    // Reference: shift the word down to the addressed lane, mask, then sign-fix
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = 32'd0;
        case (o)
            3'b000, 3'b100: begin
                v = (d >> (32'd8 * (a % 32'd4))) & 32'h0000_00FF;
                if (o == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                v = (d >> (32'd16 * ((a / 32'd2) % 32'd2))) & 32'h0000_FFFF;
                if (o == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            3'b010:  v = d;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // One complete load; wt = WAIT cycles before mem_rvalid, to = never answer
    task automatic do_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                           input int wt, input bit to);
        logic [31:0] exp;
        int n;
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        step();
        req_valid = 1'b0;
        op        = 3'($urandom);
        addr      = $urandom;
        if (!is_legal(o) || is_trap(o, a)) begin
            check("fault_valid", 32'(rsp_valid), 32'd1);
            check("fault_err", 32'(rsp_err), 32'd1);
            check("fault_data", rsp_data, 32'd0);
            check("fault_no_rd", 32'(mem_rd_en), 32'd0);
            check("fault_busy", 32'(req_ready), 32'd0);
            step();
            check("fault_pulse", 32'(rsp_valid), 32'd0);
            check("fault_no_rd2", 32'(mem_rd_en), 32'd0);
            check("fault_ready", 32'(req_ready), 32'd1);
            check("fault_hold", rsp_data, 32'd0);
            return;
        end
        check("rd_en", 32'(mem_rd_en), 32'd1);
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("busy", 32'(req_ready), 32'd0);
        step();
        check("rd_en_once", 32'(mem_rd_en), 32'd0);
        check("mem_addr_idle", mem_addr, 32'd0);
        if (to) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 4 * T) begin
                step();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(T));
            check("timeout_err", 32'(rsp_err), 32'd1);
            check("timeout_data", rsp_data, 32'd0);
            exp = 32'd0;
        end else begin
            for (int k = 0; k < wt; k++) begin
                check("no_early_rsp", 32'(rsp_valid), 32'd0);
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            exp = model(o, a, d);
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_err", 32'(rsp_err), 32'd0);
            check("rsp_data", rsp_data, exp);
        end
        step();
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("data_hold", rsp_data, exp);
    endtask

    initial begin
        logic [31:0] held;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        op         = 3'b000;
        addr       = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed loads
        do_load(3'b000, 32'h0000_0103, 32'h80FF_1234, 0, 1'b0);   // lb -> FFFFFF80
        do_load(3'b000, 32'h0000_0103, 32'h80FF_1234, 1, 1'b0);
        do_load(3'b101, 32'h0000_0202, 32'h9ABC_5678, 2, 1'b0);   // lhu -> 00009ABC
        do_load(3'b001, 32'h0000_0202, 32'h9ABC_5678, 0, 1'b0);   // lh  -> FFFF9ABC
        do_load(3'b100, 32'h0000_0011, 32'h0000_F300, 0, 1'b0);   // lbu high bit set
        do_load(3'b010, 32'h0000_0400, 32'hCAFE_F00D, T - 1, 1'b0); // data at timeout edge
        do_load(3'b010, 32'h0000_0404, 32'h0, 0, 1'b1);           // timeout
        do_load(3'b011, 32'h0000_0100, 32'h0, 0, 1'b0);           // illegal op
        do_load(3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 1, 1'b0);   // misaligned lw
        do_load(3'b001, 32'h0000_0105, 32'h8001_7FFE, 0, 1'b0);   // misaligned lh

        // Stray read data in IDLE must not produce a response
        held = rsp_data;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        check("stray_rvalid", 32'(rsp_valid), 32'd0);
        check("stray_hold", rsp_data, held);

        // Randomized loads
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  r_o;
            logic [31:0] r_a;
            logic [31:0] r_d;
            r_o = 3'($urandom_range(0, 7));
            r_a = $urandom;
            r_d = $urandom;
            do_load(r_o, r_a, r_d, int'($urandom_range(0, T - 1)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                held = rsp_data;
                mem_rvalid = 1'b1;
                step();
                mem_rvalid = 1'b0;
                check("rnd_stray", 32'(rsp_valid), 32'd0);
                check("rnd_stray_hold", rsp_data, held);
            end
        end

        // Reset in the middle of a WAIT, then late read data
        req_valid = 1'b1;
        op        = 3'b010;
        addr      = 32'h0000_0300;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5_5A5A;
        step();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_rsp_valid", 32'(rsp_valid), 32'd0);
            check("late_rsp_err", 32'(rsp_err), 32'd0);
            check("late_rsp_data", rsp_data, 32'd0);
            check("late_rd_en", 32'(mem_rd_en), 32'd0);
            check("late_maddr", mem_addr, 32'd0);
            check("late_ready", 32'(req_ready), 32'd1);
            step();
        end

        // Unit still usable after the abort
        do_load(3'b100, 32'h0000_0502, 32'h00C3_0000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
